// File: rtl/hack_pkg.sv
// Shared definitions for the Hack-style word memory blocks: word width, word type
// and the ram_reader state encoding.
package hack_pkg;

  localparam int DATA_W = 16;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } ram_reader_state_t;

endpackage

// File: rtl/ram_reader.sv
// Burst reader for a Hack word RAM: streams `count` words from `start_addr` on valid/ready.
// Optional macro RAM_READER_ABORT_EN adds an abort input that drops an active burst.
module ram_reader #(
  parameter int DATA_W = hack_pkg::DATA_W,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
`ifdef RAM_READER_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  import hack_pkg::*;

  localparam logic [ADDR_W:0]   REM_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  ram_reader_state_t state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic              handshake;
  logic              abort_hit;

  assign mem_addr  = ptr;
  assign handshake = out_valid && out_ready;

`ifdef RAM_READER_ABORT_EN
  assign abort_hit = abort && (state == FETCH || state == HOLD);
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (count == '0) ? DONE : FETCH;
      FETCH:   state_n = HOLD;
      HOLD:    if (handshake && remaining == REM_ONE) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_hit) state_n = IDLE;
  end

  // Control and output register; out_data only moves on FETCH or a handshake,
  // so it stays put under backpressure regardless of memory activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
      if (abort_hit) begin
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && count != '0) begin
              ptr       <= start_addr;
              remaining <= count;
            end
          end
          FETCH: begin
            out_data  <= mem_rdata;
            out_valid <= 1'b1;
            ptr       <= ptr + PTR_ONE;
          end
          HOLD: begin
            if (handshake) begin
              if (remaining > REM_ONE) begin
                out_data  <= mem_rdata;
                ptr       <= ptr + PTR_ONE;
                remaining <= remaining - REM_ONE;
              end else begin
                out_valid <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_reader.sv
// Self-checking bench for ram_reader on a RAM8: table-driven bursts, hand-written
// corner sequences and randomized bursts against a queue-based reference model.
module tb_ram_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  start_addr;
  logic [3:0]  count;
  logic        busy, done, out_valid, out_ready;
  logic [2:0]  mem_addr;
  logic [15:0] mem_rdata, out_data;
  logic        abort;

  logic [15:0] mem [8];
  int n_chk = 0;
  int n_fail = 0;

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  ram_reader #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .count(count),
`ifdef RAM_READER_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    int sa;
    int cnt;
    int pct;
    bit inj;
    int first;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    mem[0] = 16'd0;     mem[1] = 16'h8285; mem[2] = 16'd12345; mem[3] = 16'd1;
    mem[4] = 16'd2;     mem[5] = 16'd4;    mem[6] = 16'd8;     mem[7] = 16'd16;
  endtask

  // Expected words come straight from the memory array with modulo-8 addressing.
  task automatic run_burst(input int sa, input int cnt, input int pct, input bit inj,
                           input int exp_first);
    int q[$];
    int cyc, first_v, w;
    bit seen_done, first_done;
    for (int i = 0; i < cnt; i++) q.push_back(int'(mem[(sa + i) % 8]));
    start = 1'b1; start_addr = sa[2:0]; count = cnt[3:0];
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    cyc = 0; first_v = -1; seen_done = 1'b0; first_done = 1'b0;
    while (!seen_done && cyc < 300) begin
      if (done === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        if (busy !== 1'b1) chk("busy_in_burst", busy, 1);
        if (out_valid && first_v < 0) first_v = cyc;
        out_ready = ($urandom_range(99) < pct);
        if (inj) begin
          start = (cyc == 2); start_addr = 3'd5; count = 4'd2;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("extra_word", 1, 0);
          else begin
            w = q.pop_front();
            if (!first_done && exp_first >= 0) chk("first_word", out_data, exp_first);
            first_done = 1'b1;
            chk("word", out_data, w);
          end
        end
        tick();
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_seen", seen_done, 1);
    chk("words_left", q.size(), 0);
    if (cnt == 0) begin
      chk("zero_no_valid", first_v, -1);
      chk("zero_done_cyc", cyc, 0);
    end else if (pct == 100) begin
      chk("first_valid_cyc", first_v, 1);
      chk("done_cyc", cyc, first_v + cnt);
    end
    tick();
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("valid_after_done", out_valid, 0);
  endtask

  initial begin
    vecs[0] = '{sa: 1, cnt: 3, pct: 100, inj: 1'b0, first: 'h8285};
    vecs[1] = '{sa: 6, cnt: 8, pct: 100, inj: 1'b0, first: 8};
    vecs[2] = '{sa: 3, cnt: 0, pct: 100, inj: 1'b0, first: -1};
    vecs[3] = '{sa: 4, cnt: 4, pct: 100, inj: 1'b1, first: 2};
    vecs[4] = '{sa: 7, cnt: 1, pct: 100, inj: 1'b0, first: 16};
    vecs[5] = '{sa: 2, cnt: 6, pct: 50,  inj: 1'b0, first: 12345};

    preload();
    rst_n = 1'b0; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b1; abort = 1'b0;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", mem_addr, 0);
    #9 rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_burst(vecs[i].sa, vecs[i].cnt, vecs[i].pct, vecs[i].inj, vecs[i].first);

    // Backpressure: word held while sink stalls and memory is rewritten.
    out_ready = 1'b0;
    start = 1'b1; start_addr = 3'd1; count = 4'd3;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) mem[1] = 16'd0;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 16'h8285);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_rel_w0", out_data, 16'h8285);
    tick();
    chk("bp_rel_w1", out_data, 16'd12345);
    tick();
    chk("bp_rel_w2", out_data, 16'd1);
    chk("bp_rel_valid", out_valid, 1);
    tick();
    chk("bp_done", done, 1);
    chk("bp_valid_low", out_valid, 0);
    tick();
    chk("bp_idle", busy, 0);
    preload();

    // Asynchronous reset in the middle of HOLD.
    out_ready = 1'b0;
    start = 1'b1; start_addr = 3'd1; count = 4'd8;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", mem_addr, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_valid", out_valid, 0);
    end

`ifdef RAM_READER_ABORT_EN
    out_ready = 1'b1;
    start = 1'b1; start_addr = 3'd0; count = 4'd5;
    tick();
    start = 1'b0;
    tick();
    chk("ab_w0", out_data, 16'd0);
    chk("ab_w0_valid", out_valid, 1);
    tick();
    chk("ab_w1_presented", out_data, 16'h8285);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_valid", out_valid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_no_done", done, 0);
      chk("ab_stay_idle", busy, 0);
    end
`endif

    // Randomized bursts over random memory contents.
    for (int i = 0; i < 8; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 25; n++) begin
      run_burst(int'($urandom_range(7)), int'($urandom_range(8)),
                int'($urandom_range(100, 30)), 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
